// File: rtl/placar_jogo.sv
// Score, lives and wave controller: counts enemy deaths as falling edges of the alive array,
// keeps a saturating BCD score, runs the play / wave-clear / game-over FSM and drives the HEX displays.
module placar_jogo #(
  parameter int unsigned N_INIMIGOS         = 20,
  parameter int unsigned N_DIGITOS          = 4,
  parameter int unsigned PONTOS_POR_INIMIGO = 1,
  parameter int unsigned VIDAS_INICIAIS     = 3,
  parameter int unsigned CICLOS_ONDA_LIMPA  = 50_000_000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   pausa,
  input  logic [N_INIMIGOS-1:0]  inimigo_vivo_array,
  input  logic                   nave_atingida,
  output logic                   nova_onda,
  output logic [4*N_DIGITOS-1:0] pontos_bcd,
  output logic [7*N_DIGITOS-1:0] hex,
  output logic [1:0]             vidas,
  output logic [3:0]             onda,
  output logic [1:0]             estado,
  output logic                   perdeu
);

  localparam int unsigned PW = $clog2(N_INIMIGOS * 2 + 1);
  localparam int unsigned TW = (CICLOS_ONDA_LIMPA > 1) ? $clog2(CICLOS_ONDA_LIMPA) : 1;

  typedef enum logic [1:0] {
    JOGANDO    = 2'd0,
    ONDA_LIMPA = 2'd1,
    FIM        = 2'd2
  } estado_t;

  estado_t                estado_q;
  logic [N_INIMIGOS-1:0]  vivo_q;
  logic [PW-1:0]          pendente_q;
  logic [4*N_DIGITOS-1:0] pontos_q;
  logic [7*N_DIGITOS-1:0] hex_q;
  logic [1:0]             vidas_q;
  logic [3:0]             onda_q;
  logic [TW-1:0]          timer_q;
  logic                   armado_q;
  logic                   nova_onda_q;

  logic [N_INIMIGOS-1:0]  mortes;
  logic [PW-1:0]          n_mortes;
  logic [PW-1:0]          pendente_d;
  logic [4*N_DIGITOS-1:0] soma;
  logic [7*N_DIGITOS-1:0] hex_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign mortes = vivo_q & ~inimigo_vivo_array;

  always_comb begin
    n_mortes = '0;
    for (int i = 0; i < int'(N_INIMIGOS); i++) begin
      n_mortes = n_mortes + PW'(mortes[i]);
    end
    pendente_d = pendente_q + n_mortes - PW'(pendente_q != '0);
  end

  // BCD ripple add; a carry out of the top digit pins the score at all nines.
  always_comb begin
    logic [4:0] parcela;
    logic [4:0] dig;
    soma    = '0;
    parcela = 5'(PONTOS_POR_INIMIGO);
    dig     = '0;
    for (int i = 0; i < int'(N_DIGITOS); i++) begin
      dig = {1'b0, pontos_q[4*i +: 4]} + parcela;
      if (dig > 5'd9) begin
        soma[4*i +: 4] = 4'(dig - 5'd10);
        parcela        = 5'd1;
      end else begin
        soma[4*i +: 4] = dig[3:0];
        parcela        = 5'd0;
      end
    end
    if (parcela != 5'd0) begin
      for (int i = 0; i < int'(N_DIGITOS); i++) begin
        soma[4*i +: 4] = 4'd9;
      end
    end
  end

  // Scan from the top digit down; blank until the first non-zero digit, digit 0 always shown.
  always_comb begin
    logic visivel;
    visivel = 1'b0;
    hex_d   = '1;
    for (int i = int'(N_DIGITOS) - 1; i >= 0; i--) begin
      if (pontos_q[4*i +: 4] != 4'd0 || i == 0) begin
        visivel = 1'b1;
      end
      hex_d[7*i +: 7] = visivel ? seg7(pontos_q[4*i +: 4]) : 7'h7F;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      estado_q    <= JOGANDO;
      vivo_q      <= inimigo_vivo_array;
      pendente_q  <= '0;
      pontos_q    <= '0;
      hex_q       <= '1;
      hex_q[6:0]  <= 7'h40;
      vidas_q     <= 2'(VIDAS_INICIAIS);
      onda_q      <= 4'd1;
      timer_q     <= '0;
      armado_q    <= 1'b0;
      nova_onda_q <= 1'b0;
    end else if (pausa) begin
      nova_onda_q <= 1'b0;
    end else begin
      nova_onda_q <= 1'b0;
      vivo_q      <= inimigo_vivo_array;
      pendente_q  <= pendente_d;
      hex_q       <= hex_d;
      if (pendente_q != '0) begin
        pontos_q <= soma;
      end
      case (estado_q)
        JOGANDO: begin
          if (inimigo_vivo_array != '0) begin
            armado_q <= 1'b1;
          end
          if (nave_atingida && vidas_q != 2'd0) begin
            vidas_q <= vidas_q - 2'd1;
          end
          if (nave_atingida && vidas_q <= 2'd1) begin
            estado_q <= FIM;
          end else if (armado_q && inimigo_vivo_array == '0 && pendente_q == '0 &&
                       mortes == '0) begin
            estado_q <= ONDA_LIMPA;
            timer_q  <= TW'(CICLOS_ONDA_LIMPA - 1);
          end
        end
        ONDA_LIMPA: begin
          if (timer_q == '0) begin
            nova_onda_q <= 1'b1;
            onda_q      <= (onda_q == 4'd15) ? 4'd15 : onda_q + 4'd1;
            armado_q    <= 1'b0;
            estado_q    <= JOGANDO;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: estado_q <= FIM;
      endcase
    end
  end

  assign nova_onda  = nova_onda_q;
  assign pontos_bcd = pontos_q;
  assign hex        = hex_q;
  assign vidas      = vidas_q;
  assign onda       = onda_q;
  assign estado     = estado_q;
  assign perdeu     = (estado_q == FIM);

endmodule

// File: tb/tb_placar_jogo.sv
// Directed bench for placar_jogo: vector table for the first wave, hand sequences for the rest.
`timescale 1ns/1ps
module tb_placar_jogo;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        pausa;
  logic [4:0]  arr;
  logic        hit;
  logic        nova_onda;
  logic [11:0] pontos_bcd;
  logic [20:0] hex;
  logic [1:0]  vidas;
  logic [3:0]  onda;
  logic [1:0]  estado;
  logic        perdeu;

  int n_chk  = 0;
  int n_fail = 0;

  placar_jogo #(
    .N_INIMIGOS        (5),
    .N_DIGITOS         (3),
    .PONTOS_POR_INIMIGO(1),
    .VIDAS_INICIAIS    (3),
    .CICLOS_ONDA_LIMPA (4)
  ) dut (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
    .pausa             (pausa),
    .inimigo_vivo_array(arr),
    .nave_atingida     (hit),
    .nova_onda         (nova_onda),
    .pontos_bcd        (pontos_bcd),
    .hex               (hex),
    .vidas             (vidas),
    .onda              (onda),
    .estado            (estado),
    .perdeu            (perdeu)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  arr;
    logic [11:0] pontos;
    logic [1:0]  est;
    logic        nova;
    logic [3:0]  onda;
  } vec_t;

  vec_t tab [15];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  function automatic logic [20:0] enc(input logic [11:0] b);
    logic [6:0] h2, h1, h0;
    h0 = seg(b[3:0]);
    h1 = (b[11:8] != 0 || b[7:4] != 0) ? seg(b[7:4]) : 7'h7F;
    h2 = (b[11:8] != 0) ? seg(b[11:8]) : 7'h7F;
    return {h2, h1, h0};
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic kill_n(input int n);
    logic [4:0] full;
    full = 5'h1F;
    arr  = full;
    tick();
    arr = full >> n;
    tick();
    repeat (n + 1) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pontos"}, pontos_bcd, 12'h000);
    chk({tag, "_vidas"}, vidas, 2'd3);
    chk({tag, "_onda"}, onda, 4'd1);
    chk({tag, "_estado"}, estado, 2'd0);
    chk({tag, "_perdeu"}, perdeu, 1'b0);
    chk({tag, "_nova"}, nova_onda, 1'b0);
    chk({tag, "_hex"}, hex, {7'h7F, 7'h7F, 7'h40});
  endtask

  initial begin
    logic [11:0] prev;
    int bad;
    int found;
    int exp_sc;
    int n;

    tab[0]  = '{5'h1F, 12'h000, 2'd0, 1'b0, 4'd1};
    tab[1]  = '{5'h1E, 12'h000, 2'd0, 1'b0, 4'd1};
    tab[2]  = '{5'h1E, 12'h001, 2'd0, 1'b0, 4'd1};
    tab[3]  = '{5'h1E, 12'h001, 2'd0, 1'b0, 4'd1};
    tab[4]  = '{5'h00, 12'h001, 2'd0, 1'b0, 4'd1};
    tab[5]  = '{5'h00, 12'h002, 2'd0, 1'b0, 4'd1};
    tab[6]  = '{5'h00, 12'h003, 2'd0, 1'b0, 4'd1};
    tab[7]  = '{5'h00, 12'h004, 2'd0, 1'b0, 4'd1};
    tab[8]  = '{5'h00, 12'h005, 2'd0, 1'b0, 4'd1};
    tab[9]  = '{5'h00, 12'h005, 2'd1, 1'b0, 4'd1};
    tab[10] = '{5'h00, 12'h005, 2'd1, 1'b0, 4'd1};
    tab[11] = '{5'h00, 12'h005, 2'd1, 1'b0, 4'd1};
    tab[12] = '{5'h00, 12'h005, 2'd1, 1'b0, 4'd1};
    tab[13] = '{5'h00, 12'h005, 2'd0, 1'b1, 4'd2};
    tab[14] = '{5'h00, 12'h005, 2'd0, 1'b0, 4'd2};

    reset = 1'b1;
    pausa = 1'b0;
    arr   = 5'h1F;
    hit   = 1'b0;
    tick();
    reset = 1'b0;
    chk_reset("rst0");

    // First wave: single kill latency, burst of four, clear and respawn pulse.
    prev = 12'h000;
    for (int i = 0; i < 15; i++) begin
      arr = tab[i].arr;
      tick();
      chk($sformatf("v%0d_pontos", i), pontos_bcd, tab[i].pontos);
      chk($sformatf("v%0d_estado", i), estado, tab[i].est);
      chk($sformatf("v%0d_nova", i), nova_onda, tab[i].nova);
      chk($sformatf("v%0d_onda", i), onda, tab[i].onda);
      chk($sformatf("v%0d_hex", i), hex, enc(prev));
      prev = tab[i].pontos;
    end

    // Empty array right after respawn is not a clear.
    arr = 5'h00;
    bad = 0;
    repeat (10) begin
      tick();
      if (estado != 2'd0 || nova_onda) bad++;
    end
    chk("sem_limpeza_pos_onda", bad, 0);
    arr = 5'h1F;
    tick();
    arr = 5'h00;
    tick();
    repeat (5) tick();
    chk("onda2_pontos", pontos_bcd, 12'h010);
    tick();
    chk("onda2_limpa", estado, 2'd1);
    found = 0;
    for (int k = 1; k <= 10 && found == 0; k++) begin
      tick();
      if (nova_onda) begin
        found = 1;
        chk("onda2_latencia", k, 4);
      end
    end
    chk("onda2_nova_vista", found, 1);
    chk("onda2_onda", onda, 4'd3);
    tick();
    chk("onda2_pulso_unico", nova_onda, 1'b0);

    // Pause freezes kills, hits and score.
    arr = 5'h1F;
    tick();
    pausa = 1'b1;
    arr   = 5'h1C;
    hit   = 1'b1;
    tick();
    hit = 1'b0;
    repeat (19) tick();
    chk("pausa_pontos", pontos_bcd, 12'h010);
    chk("pausa_vidas", vidas, 2'd3);
    chk("pausa_estado", estado, 2'd0);
    chk("pausa_hex", hex, enc(12'h010));
    pausa = 1'b0;
    repeat (3) tick();
    chk("despausa_pontos", pontos_bcd, 12'h012);
    chk("despausa_vidas", vidas, 2'd3);

    // Lives and game over.
    hit = 1'b1;
    tick();
    chk("vida_2", vidas, 2'd2);
    hit = 1'b0;
    tick();
    hit = 1'b1;
    tick();
    chk("vida_1", vidas, 2'd1);
    chk("vida_1_estado", estado, 2'd0);
    tick();
    chk("vida_0", vidas, 2'd0);
    chk("fim_estado", estado, 2'd2);
    chk("fim_perdeu", perdeu, 1'b1);
    tick();
    tick();
    hit = 1'b0;
    chk("fim_absorve", estado, 2'd2);
    chk("fim_vidas_sat", vidas, 2'd0);
    arr = 5'h18;
    repeat (3) tick();
    chk("fim_kill_pontua", pontos_bcd, 12'h013);

    // Climb to 997 inside FIM, then saturate.
    exp_sc = 13;
    while (exp_sc < 997) begin
      n = (997 - exp_sc > 5) ? 5 : 997 - exp_sc;
      kill_n(n);
      exp_sc += n;
    end
    chk("quase_max_pontos", pontos_bcd, to_bcd(exp_sc));
    chk("quase_max_hex", hex, {7'h10, 7'h10, 7'h78});
    kill_n(5);
    chk("sat_pontos", pontos_bcd, 12'h999);
    chk("sat_hex", hex, {7'h10, 7'h10, 7'h10});
    chk("sat_estado", estado, 2'd2);

    // Reset out of FIM, then reset in the middle of ONDA_LIMPA.
    reset = 1'b1;
    arr   = 5'h1F;
    tick();
    reset = 1'b0;
    chk_reset("rst1");
    tick();
    arr = 5'h00;
    tick();
    repeat (5) tick();
    tick();
    chk("rst2_limpa", estado, 2'd1);
    chk("rst2_pontos", pontos_bcd, 12'h005);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset("rst2");
    bad = 0;
    repeat (10) begin
      tick();
      if (nova_onda || estado != 2'd0 || pontos_bcd != 12'h000) bad++;
    end
    chk("rst2_sem_nova", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
